// File: rtl/eviction_write_buffer_if.sv
// Upstream line port plus physical-memory port of the eviction buffer.
// master: hierarchy/memory side; slave: the buffer itself.
interface eviction_write_buffer_if #(
  parameter int s_line = 256
) ();
  logic              up_read;
  logic              up_write;
  logic [31:0]       up_address;
  logic [s_line-1:0] up_wdata;
  logic [s_line-1:0] up_rdata;
  logic              up_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output up_read, up_write, up_address, up_wdata,
    output pmem_rdata, pmem_resp,
    input  up_rdata, up_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  up_read, up_write, up_address, up_wdata,
    input  pmem_rdata, pmem_resp,
    output up_rdata, up_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/eviction_write_buffer.sv
// Write-back buffer between cache hierarchy and memory: absorbs evictions,
// forwards hits, drains FIFO-order when idle. Ports: clk, rst, bus (slave).
module eviction_write_buffer #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int DEPTH    = 4
) (
  input logic                   clk,
  input logic                   rst,
  eviction_write_buffer_if.slave bus
);
  localparam int TW = 32 - s_offset;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RESP, MEM_READ, DRAIN} state_t;

  state_t            state;
  logic [DEPTH-1:0]  valid;
  logic [TW-1:0]     tag  [DEPTH];
  logic [s_line-1:0] data [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [s_line-1:0] rdata_q;
  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic [TW-1:0]     up_tag;
  logic              push;
  logic              coal;
  logic              unused_low;

  assign up_tag     = bus.up_address[31:s_offset];
  assign unused_low = ^bus.up_address[s_offset-1:0];

  // Coalescing guarantees at most one valid entry per tag.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag[i] == up_tag) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign push = (state == IDLE) && !bus.up_read && bus.up_write &&
                !hit && (count != FULL);
  assign coal = (state == IDLE) && !bus.up_read && bus.up_write && hit;

  always_ff @(posedge clk) begin
    if (push) begin
      tag[tail]  <= up_tag;
      data[tail] <= bus.up_wdata;
    end else if (coal) begin
      data[hit_idx] <= bus.up_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.up_read) begin
            if (hit) begin
              rdata_q <= data[hit_idx];
              state   <= RESP;
            end else begin
              state <= MEM_READ;
            end
          end else if (bus.up_write) begin
            if (coal) begin
              state <= RESP;
            end else if (push) begin
              valid[tail] <= 1'b1;
              tail        <= tail + PW'(1);
              count       <= count + CW'(1);
              state       <= RESP;
            end else begin
              // Full: drain one line, the write is retried in IDLE.
              state <= DRAIN;
            end
          end else if (count != '0) begin
            state <= DRAIN;
          end
        end
        RESP: state <= IDLE;
        MEM_READ: begin
          if (bus.pmem_resp) begin
            rdata_q <= bus.pmem_rdata;
            state   <= RESP;
          end
        end
        DRAIN: begin
          if (bus.pmem_resp) begin
            valid[head] <= 1'b0;
            head        <= head + PW'(1);
            count       <= count - CW'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.up_rdata   = rdata_q;
  assign bus.up_resp    = (state == RESP);
  assign bus.pmem_read  = (state == MEM_READ);
  assign bus.pmem_write = (state == DRAIN);

  always_comb begin
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    if (state == MEM_READ) begin
      bus.pmem_address = {up_tag, {s_offset{1'b0}}};
    end else if (state == DRAIN) begin
      bus.pmem_address = {tag[head], {s_offset{1'b0}}};
      bus.pmem_wdata   = data[head];
    end
  end
endmodule

// File: doc/eviction_write_buffer.md
Name: eviction_write_buffer

Overview:
- Write-back buffer placed between the cache hierarchy's physical-memory port and physical memory.
- Absorbs dirty-line evictions from L2 so the L2 read miss that follows is not serialised behind the write-back.
- Forwards buffered lines to reads that hit in the buffer.
- Drains buffered lines to memory in FIFO order whenever the upstream port is idle.

Parameters:
s_offset, 5, byte-offset bits in a line; match and pmem addresses ignore these bits
s_line, 256, line width in bits
DEPTH, 4, number of buffered lines, power of two, at least 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
up_read  input  1  line read request from hierarchy, held until up_resp
up_write  input  1  line write (eviction) from hierarchy, held until up_resp
up_address  input  32  request address
up_wdata  input  s_line  eviction data
up_rdata  output  s_line  read data, valid while up_resp=1
up_resp  output  1  one-cycle completion pulse
pmem_read  output  1  memory read request
pmem_write  output  1  memory write request
pmem_address  output  32  line-aligned memory address
pmem_wdata  output  s_line  memory write data
pmem_rdata  input  s_line  memory read data
pmem_resp  input  1  memory completion pulse

Behaviour:
- Storage: DEPTH entries of {valid, tag = address[31:s_offset], data}; head and tail pointers of width log2(DEPTH) wrap modulo DEPTH; count 0..DEPTH.
- Match: address[31:s_offset] compared against valid entries only; at most one entry matches because of coalescing.
- FSM states: IDLE, RESP, MEM_READ, DRAIN.
- IDLE decisions, in priority order:
  - up_read and match: load up_rdata from the matching entry, go to RESP.
  - up_read and no match: go to MEM_READ.
  - up_write and match: overwrite that entry's data in place (coalesce, count unchanged), go to RESP.
  - up_write, no match, count<DEPTH: push at tail, count+1, go to RESP.
  - up_write, no match, count==DEPTH: go to DRAIN; the write stays pending and is re-evaluated on return to IDLE.
  - No request and count>0: go to DRAIN.
  - Otherwise stay in IDLE.
- up_read and up_write asserted together is illegal; read wins.
- RESP: up_resp=1 for exactly one cycle, then IDLE. Upstream may present a new request in the following cycle.
- MEM_READ: pmem_read=1, pmem_address={up_address[31:s_offset], 0}. On pmem_resp, register pmem_rdata into up_rdata and go to RESP.
- DRAIN: pmem_write=1, pmem_address={head tag, 0}, pmem_wdata=head data. On pmem_resp, invalidate head, head+1, count-1, go to IDLE. Requests are not serviced until the drain completes.
- Latency:
  - Buffer hit or accepted write: request sampled in IDLE cycle N, up_resp in N+1.
  - Read miss: pmem_resp in cycle M, up_resp in M+1.
- Outputs are decoded from state. pmem_address and pmem_wdata are 0 outside MEM_READ and DRAIN. up_rdata holds its last loaded value.
- Ordering: reads never bypass a buffered write to the same line, because a match always forwards. Writes to distinct lines reach memory in arrival order.
- Reset (asynchronous, any state including mid-DRAIN or mid-MEM_READ):
  - FSM goes to IDLE; all valids, pointers and count go to 0; up_rdata goes to 0.
  - up_resp, pmem_read and pmem_write deassert immediately.
  - Buffered data is discarded.
  - A pmem_resp arriving after reset is ignored.

Test Plan:
- Write 0x100 with data A, no further requests: up_resp 1 cycle after up_write, no pmem activity that cycle; next IDLE cycle enters DRAIN with pmem_write=1, pmem_address=0x100, pmem_wdata=A; after pmem_resp, count=0.
- Forwarding: write 0x200=B, then immediately read 0x204: up_resp next cycle, up_rdata=B, pmem_read never asserted.
- Coalescing: write 0x300=C, then back-to-back write 0x31F=D: count=1; the drain issues exactly one pmem_write to 0x300 with D.
- Full buffer: DEPTH=4, back-to-back writes to 0x000, 0x020, 0x040, 0x060, then a 5th write to 0x080 held high:
  - pmem_write to 0x000 first.
  - After pmem_resp, the 0x080 write is accepted and up_resp pulses.
  - Drain order afterwards is 0x020, 0x040, 0x060, 0x080.
- Read miss: read 0x400 with an empty buffer: pmem_read=1, pmem_address=0x400; pmem_resp with E gives up_resp next cycle with up_rdata=E.
- Reset mid-DRAIN: assert rst while pmem_write=1: pmem_write drops the same cycle; after release count=0 and a read of the previously buffered address goes to MEM_READ.
